// File: rtl/two_bit_predictor_pkg.sv
// two_bit_predictor_pkg: shared counter states, table entry layout and defaults
package two_bit_predictor_pkg;
  localparam int ENTRIES_DEF = 16;
  localparam int TAG_MAX_W = 30;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;
  typedef struct packed {
    logic valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0] target;
    ctr_t ctr;
  } entry_t;
endpackage

// File: rtl/two_bit_predictor_if.sv
// two_bit_predictor_if: fetch lookup, EX update and statistics bundle
interface two_bit_predictor_if;
  logic [31:0] pc_IF;
  logic pred_taken_o;
  logic [31:0] pred_pc_o;
  logic upd_valid_i;
  logic [31:0] upd_pc_i;
  logic upd_taken_i;
  logic [31:0] upd_target_i;
  logic upd_is_jump_i;
  logic mispred_i;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispred_cnt_o;
  modport master (
    output pc_IF, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_is_jump_i, mispred_i,
    input pred_taken_o, pred_pc_o, branch_cnt_o, mispred_cnt_o
  );
  modport slave (
    input pc_IF, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_is_jump_i, mispred_i,
    output pred_taken_o, pred_pc_o, branch_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/two_bit_predictor_sat_counter2.sv
// sat_counter2: next state of a 2-bit saturating taken/not-taken counter
module sat_counter2
  import two_bit_predictor_pkg::*;
(
  input  ctr_t cur,
  input  logic taken,
  output ctr_t nxt
);
  assign nxt = taken ? ((cur == ST) ? ST : ctr_t'(cur + 2'd1))
                     : ((cur == SNT) ? SNT : ctr_t'(cur - 2'd1));
endmodule

// File: rtl/two_bit_predictor.sv
// two_bit_predictor: direct-mapped 2-bit branch predictor with target store and counters
module two_bit_predictor
  import two_bit_predictor_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEF,
  parameter int IDX_W = $clog2(ENTRIES)
) (
  input logic clk_i,
  input logic rst_i,
  two_bit_predictor_if.slave bus
);
  entry_t tbl [ENTRIES];
  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_MAX_W-1:0] l_tag, u_tag;
  entry_t l_ent, u_ent;
  logic l_hit, u_hit;
  ctr_t u_nxt;
  logic [31:0] branch_cnt, mispred_cnt;
  logic unused;
  assign unused = ^{bus.pc_IF[1:0], bus.upd_pc_i[1:0]};
  assign l_idx = bus.pc_IF[IDX_W+1:2];
  assign u_idx = bus.upd_pc_i[IDX_W+1:2];
  assign l_tag = TAG_MAX_W'(bus.pc_IF[31:IDX_W+2]);
  assign u_tag = TAG_MAX_W'(bus.upd_pc_i[31:IDX_W+2]);
  assign l_ent = tbl[l_idx];
  assign u_ent = tbl[u_idx];
  assign l_hit = l_ent.valid && l_ent.tag == l_tag;
  assign u_hit = u_ent.valid && u_ent.tag == u_tag;
  assign bus.pred_taken_o = l_hit && l_ent.ctr[1];
  assign bus.pred_pc_o = bus.pred_taken_o ? l_ent.target : bus.pc_IF + 32'd4;
  assign bus.branch_cnt_o = branch_cnt;
  assign bus.mispred_cnt_o = mispred_cnt;
  sat_counter2 u_sat (.cur(u_ent.ctr), .taken(bus.upd_taken_i), .nxt(u_nxt));
  // table update: jumps force ST, hits train, taken misses allocate at WT
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
    end else if (bus.upd_valid_i) begin
      if (bus.upd_is_jump_i) tbl[u_idx] <= '{valid: 1'b1, tag: u_tag, target: bus.upd_target_i, ctr: ST};
      else if (u_hit) begin
        tbl[u_idx].ctr <= u_nxt;
        if (bus.upd_taken_i) tbl[u_idx].target <= bus.upd_target_i;
      end else if (bus.upd_taken_i) tbl[u_idx] <= '{valid: 1'b1, tag: u_tag, target: bus.upd_target_i, ctr: WT};
    end
  end
  // resolved-branch and mispredict statistics, wrapping at 2^32
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt <= '0;
      mispred_cnt <= '0;
    end else if (bus.upd_valid_i) begin
      branch_cnt <= branch_cnt + 32'd1;
      mispred_cnt <= mispred_cnt + 32'(bus.mispred_i);
    end
  end
endmodule

// File: tb/tb_two_bit_predictor.sv
// tb_two_bit_predictor: directed checks of lookup, training, allocation, aliasing and reset
module tb_two_bit_predictor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  two_bit_predictor_if bus ();
  two_bit_predictor #(.ENTRIES(16)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic jmp, input logic mp);
    bus.upd_valid_i = 1'b1;
    bus.upd_pc_i = pc;
    bus.upd_taken_i = tk;
    bus.upd_target_i = tgt;
    bus.upd_is_jump_i = jmp;
    bus.mispred_i = mp;
    tick();
    bus.upd_valid_i = 1'b0;
    bus.mispred_i = 1'b0;
  endtask
  task automatic look(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] npc);
    bus.pc_IF = pc;
    #1;
    chk({tag, "_taken"}, 32'(bus.pred_taken_o), 32'(tk));
    chk({tag, "_pc"}, bus.pred_pc_o, npc);
  endtask
  initial begin
    bus.pc_IF = 32'h100;
    bus.upd_valid_i = 1'b0;
    bus.upd_pc_i = '0;
    bus.upd_taken_i = 1'b0;
    bus.upd_target_i = '0;
    bus.upd_is_jump_i = 1'b0;
    bus.mispred_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    look("reset", 32'h100, 1'b0, 32'h104);
    chk("reset_bcnt", bus.branch_cnt_o, 32'd0);
    chk("reset_mcnt", bus.mispred_cnt_o, 32'd0);
    upd(32'h100, 1'b1, 32'h80, 1'b0, 1'b0);
    look("alloc", 32'h100, 1'b1, 32'h80);
    chk("alloc_bcnt", bus.branch_cnt_o, 32'd1);
    upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b1);
    look("wnt", 32'h100, 1'b0, 32'h104);
    upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b1);
    look("snt", 32'h100, 1'b0, 32'h104);
    chk("snt_mcnt", bus.mispred_cnt_o, 32'd2);
    upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    upd(32'h100, 1'b1, 32'h80, 1'b0, 1'b0);
    look("snt_sat", 32'h100, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h80, 1'b0, 1'b0);
    look("retrain", 32'h100, 1'b1, 32'h80);
    bus.mispred_i = 1'b1;
    tick();
    bus.mispred_i = 1'b0;
    chk("idle_mispred_mcnt", bus.mispred_cnt_o, 32'd2);
    chk("idle_mispred_bcnt", bus.branch_cnt_o, 32'd6);
    upd(32'h200, 1'b1, 32'h400, 1'b1, 1'b0);
    look("jump", 32'h200, 1'b1, 32'h400);
    upd(32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
    look("jump_st", 32'h200, 1'b1, 32'h400);
    upd(32'h240, 1'b1, 32'h10, 1'b0, 1'b0);
    look("alias_old", 32'h200, 1'b0, 32'h204);
    look("alias_new", 32'h240, 1'b1, 32'h10);
    bus.pc_IF = 32'h300;
    bus.upd_valid_i = 1'b1;
    bus.upd_pc_i = 32'h300;
    bus.upd_taken_i = 1'b1;
    bus.upd_target_i = 32'h500;
    bus.upd_is_jump_i = 1'b0;
    #1;
    chk("same_cycle_pc", bus.pred_pc_o, 32'h304);
    tick();
    bus.upd_valid_i = 1'b0;
    look("after_same", 32'h300, 1'b1, 32'h500);
    upd(32'h300, 1'b1, 32'h600, 1'b0, 1'b0);
    look("retarget", 32'h300, 1'b1, 32'h600);
    chk("final_bcnt", bus.branch_cnt_o, 32'd11);
    chk("final_mcnt", bus.mispred_cnt_o, 32'd2);
    #2;
    rst = 1'b1;
    look("async_rst", 32'h300, 1'b0, 32'h304);
    chk("async_rst_bcnt", bus.branch_cnt_o, 32'd0);
    chk("async_rst_mcnt", bus.mispred_cnt_o, 32'd0);
    upd(32'h100, 1'b1, 32'h80, 1'b0, 1'b1);
    rst = 1'b0;
    look("rst_upd", 32'h100, 1'b0, 32'h104);
    chk("rst_upd_bcnt", bus.branch_cnt_o, 32'd0);
    chk("rst_upd_mcnt", bus.mispred_cnt_o, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
